// File: rtl/flatten_stage.sv
// flatten_stage: interleaves two layer-1 maxpool maps into the layer-2 flattened memory,
// one 2-cycle read/write pair per element.
module flatten_stage #(
   parameter int         N_SRC    = 1024,
   parameter logic [2:0] SEL_L1K0 = 3'b011,
   parameter logic [2:0] SEL_L1K1 = 3'b100,
   parameter logic [2:0] SEL_L2   = 3'b101
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [19:0] cdata_rd,
   output logic        crd,
   output logic [11:0] caddr_rd,
   output logic        cwr,
   output logic [11:0] caddr_wr,
   output logic [19:0] cdata_wr,
   output logic [2:0]  csel,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   localparam logic [11:0] K_LAST = 12'(2 * N_SRC - 1);
   state_t      r_state;
   logic [11:0] r_k;
   logic        r_crd, r_cwr, r_busy, r_done;
   logic [11:0] r_caddr_rd, r_caddr_wr;
   logic [19:0] r_cdata_wr;
   logic [2:0]  r_csel;
   logic [11:0] w_k_nxt;
   assign w_k_nxt  = r_k + 12'd1;
   assign crd      = r_crd;
   assign cwr      = r_cwr;
   assign caddr_rd = r_caddr_rd;
   assign caddr_wr = r_caddr_wr;
   assign cdata_wr = r_cdata_wr;
   assign csel     = r_csel;
   assign busy     = r_busy;
   assign done     = r_done;
   // Outputs for the next state are loaded on the transition edge, so every port is a flop.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state    <= IDLE;
         r_k        <= '0;
         r_crd      <= 1'b0;
         r_cwr      <= 1'b0;
         r_csel     <= '0;
         r_caddr_rd <= '0;
         r_caddr_wr <= '0;
         r_cdata_wr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else
         case (r_state)
            IDLE:
               if (start) begin
                  r_state    <= READ;
                  r_k        <= '0;
                  r_crd      <= 1'b1;
                  r_csel     <= SEL_L1K0;
                  r_caddr_rd <= '0;
                  r_busy     <= 1'b1;
               end
            READ: begin
               r_state    <= WRITE;
               r_crd      <= 1'b0;
               r_cwr      <= 1'b1;
               r_csel     <= SEL_L2;
               r_caddr_wr <= r_k;
               r_cdata_wr <= cdata_rd;
            end
            WRITE: begin
               r_cwr <= 1'b0;
               if (r_k == K_LAST) begin
                  r_state <= DONE;
                  r_csel  <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= READ;
                  r_k        <= w_k_nxt;
                  r_crd      <= 1'b1;
                  r_csel     <= w_k_nxt[0] ? SEL_L1K1 : SEL_L1K0;
                  r_caddr_rd <= {1'b0, w_k_nxt[11:1]};
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
endmodule

// File: tb/tb_flatten_stage.sv
// tb_flatten_stage: directed bench with behavioural layer-1/layer-2 memories.
module tb_flatten_stage;
   localparam int         N    = 1024;
   localparam logic [2:0] SEL0 = 3'b011;
   localparam logic [2:0] SEL1 = 3'b100;
   localparam logic [2:0] SEL2 = 3'b101;
   typedef struct {
      logic [11:0] a;
      logic [19:0] d;
   } vec_t;
   logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [19:0] cdata_rd;
   logic        crd, cwr, busy, done;
   logic [11:0] caddr_rd, caddr_wr;
   logic [19:0] cdata_wr;
   logic [2:0]  csel;
   logic [19:0] l1k0[N], l1k1[N], l2[2*N];
   logic [19:0] salt = '0;
   int          n_chk = 0, n_fail = 0;
   int          wr_cnt = 0, base = 0, viol = 0, hi_wr = 0;
   logic [11:0] first_a, last_a;
   logic [19:0] first_d, last_d;
   logic [11:0] kk;
   always #5 clk = ~clk;
   flatten_stage dut (
      .clk(clk), .reset(reset), .start(start), .cdata_rd(cdata_rd),
      .crd(crd), .caddr_rd(caddr_rd), .cwr(cwr), .caddr_wr(caddr_wr),
      .cdata_wr(cdata_wr), .csel(csel), .busy(busy), .done(done)
   );
   assign cdata_rd = csel == SEL0 ? l1k0[caddr_rd[9:0]] : csel == SEL1 ? l1k1[caddr_rd[9:0]] : 20'h0;
   always @(posedge clk)
      if (cwr && !reset) begin
         if (caddr_wr > 12'd2047) hi_wr <= hi_wr + 1;
         else l2[caddr_wr[10:0]] <= cdata_wr;
         if (wr_cnt == base) begin
            first_a <= caddr_wr;
            first_d <= cdata_wr;
         end
         last_a <= caddr_wr;
         last_d <= cdata_wr;
         wr_cnt <= wr_cnt + 1;
      end
   assign kk = 12'(wr_cnt - base);
   always @(negedge clk)
      if (!reset) begin
         if (crd && cwr) viol <= viol + 1;
         if (crd && (csel != (kk[0] ? SEL1 : SEL0) || caddr_rd != {1'b0, kk[11:1]})) viol <= viol + 1;
         if (cwr && csel != SEL2) viol <= viol + 1;
      end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic fill(input logic [19:0] s);
      for (int i = 0; i < N; i++) begin
         l1k0[i] = 20'(i) ^ s;
         l1k1[i] = (20'h80000 | 20'(i)) ^ s;
      end
      if (s == 20'h0) begin
         l1k0[0]    = 20'h00001;
         l1k1[1023] = 20'hFFFFF;
      end
      salt = s;
   endtask
   function automatic logic [19:0] expv(input int a);
      logic [19:0] v;
      v = ((a % 2) == 1 ? (20'h80000 | 20'(a / 2)) : 20'(a / 2)) ^ salt;
      if (salt == 20'h0 && a == 0) v = 20'h00001;
      if (salt == 20'h0 && a == 2047) v = 20'hFFFFF;
      return v;
   endfunction
   task automatic sweep(input string nm);
      int err = 0;
      for (int a = 0; a < 2 * N; a++) if (l2[a] !== expv(a)) err++;
      chk(nm, 64'(err), 64'd0);
   endtask
   task automatic run_pass(input bit inject, output int cyc, output int bcyc);
      bit inj = 1'b0;
      base = wr_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc  = 1;
      bcyc = 0;
      while (!done && cyc < 5000) begin
         bcyc += int'(busy);
         if (inject && !inj && crd && caddr_rd == 12'd50 && csel == SEL0) begin
            start = 1'b1;
            inj   = 1'b1;
         end else start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      bcyc += int'(busy);
      start = inject;
      @(negedge clk) start = 1'b0;
   endtask
   initial begin
      vec_t tbl[8];
      int   cyc, bcyc, w0, t, act;
      tbl = '{'{12'd0, 20'h00001}, '{12'd1, 20'h80000}, '{12'd2, 20'h00001}, '{12'd3, 20'h80001},
              '{12'd200, 20'h00064}, '{12'd201, 20'h80064}, '{12'd2046, 20'h003FF}, '{12'd2047, 20'hFFFFF}};
      fill(20'h0);
      #2 reset = 1'b1;
      #1 chk("reset_outputs", 64'({crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr, busy, done}), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_quiet", 64'({busy, done, crd, cwr}), 64'd0);
      run_pass(1'b1, cyc, bcyc);
      chk("done_latency", 64'(cyc), 64'd4097);
      chk("busy_cycles", 64'(bcyc), 64'd4097);
      chk("after_done_busy_done", 64'({busy, done}), 64'd0);
      act = 0;
      repeat (5) @(negedge clk) act += int'(crd | cwr | busy);
      chk("no_restart", 64'(act), 64'd0);
      chk("write_count", 64'(wr_cnt - base), 64'd2048);
      chk("first_write", 64'({first_a, first_d}), 64'({12'd0, 20'h00001}));
      chk("last_write", 64'({last_a, last_d}), 64'({12'd2047, 20'hFFFFF}));
      chk("no_write_past_2047", 64'(hi_wr), 64'd0);
      foreach (tbl[i]) chk($sformatf("l2[%0d]", tbl[i].a), 64'(l2[tbl[i].a[10:0]]), 64'(tbl[i].d));
      sweep("l2_sweep_pass1");
      fill(20'h0F0F0);
      base = wr_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      t = 0;
      while (!(cwr && caddr_wr == 12'd500) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("reach_k500_write", 64'({cwr, caddr_wr}), 64'({1'b1, 12'd500}));
      reset = 1'b1;
      w0 = wr_cnt;
      #1 chk("midpass_reset_outputs", 64'({crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr, busy, done}), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_writes_after_reset", 64'(wr_cnt - w0), 64'd0);
      chk("idle_after_reset", 64'({busy, crd}), 64'd0);
      fill(20'h5A5A5);
      run_pass(1'b0, cyc, bcyc);
      chk("restart_latency", 64'(cyc), 64'd4097);
      chk("restart_write_count", 64'(wr_cnt - base), 64'd2048);
      chk("restart_first_write", 64'({first_a, first_d}), 64'({12'd0, 20'h5A5A5}));
      sweep("l2_sweep_restart");
      chk("protocol_violations", 64'(viol), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/flatten_stage.md
FLATTEN_STAGE -- requirements
Module: flatten_stage

Interface
REQ-001 Parameter N_SRC, 1024, number of entries in each layer-1 maxpool map.
REQ-002 Parameter SEL_L1K0, 3'b011, csel code of layer-1 map for kernel 0.
REQ-003 Parameter SEL_L1K1, 3'b100, csel code of layer-1 map for kernel 1.
REQ-004 Parameter SEL_L2, 3'b101, csel code of layer-2 flattened memory.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin flattening, sampled only in IDLE.
REQ-008 cdata_rd  input  20  read data from the memory selected by csel at caddr_rd.
REQ-009 crd  output  1  memory read strobe.
REQ-010 caddr_rd  output  12  memory read address.
REQ-011 cwr  output  1  memory write strobe.
REQ-012 caddr_wr  output  12  memory write address.
REQ-013 cdata_wr  output  20  memory write data.
REQ-014 csel  output  3  memory select, shared by read and write.
REQ-015 busy  output  1  high from the cycle after accepted start until the DONE cycle inclusive.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 All outputs SHALL be registered; memory returns cdata_rd for the csel/caddr_rd presented in a cycle by the next rising edge (1-cycle read latency).
REQ-018 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-019 IDLE: crd=0, cwr=0, csel=3'b000, busy=0, done=0; start=1 -> READ with element counter k=0.
REQ-020 Output order SHALL interleave maps: layer-2 address k takes layer-1 entry k>>1 from map SEL_L1K0 when k[0]=0, SEL_L1K1 when k[0]=1.
REQ-021 READ (one cycle): crd=1, cwr=0, csel=source map of k, caddr_rd=k>>1; at cycle end cdata_rd SHALL be captured unmodified (20-bit, no sign or rounding change) -> WRITE.
REQ-022 WRITE (one cycle): cwr=1, crd=0, csel=SEL_L2, caddr_wr=k, cdata_wr=captured value; -> READ with k+1 if k<2*N_SRC-1, else DONE.
REQ-023 Each element SHALL take exactly 2 cycles; a full pass SHALL take 2*2*N_SRC = 4096 cycles from first READ to last WRITE.
REQ-024 k SHALL be 12 bits and SHALL never wrap past 2047; last write SHALL be caddr_wr=12'd2047.
REQ-025 DONE (one cycle): done=1, busy=1, crd=0, cwr=0, csel=3'b000 -> IDLE, where busy falls.
REQ-026 start while not IDLE SHALL be ignored with no effect on k, state or outputs.
REQ-027 start in the same cycle as the DONE->IDLE transition SHALL be ignored; a new start is accepted only while in IDLE.
REQ-028 cwr and crd SHALL never be high in the same cycle.
REQ-029 cdata_wr and caddr_wr SHALL hold their last values outside WRITE; caddr_rd SHALL hold its last value outside READ.

Reset
REQ-030 reset=1 SHALL force IDLE, k=0, crd=0, cwr=0, csel=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, busy=0, done=0 immediately, independent of clk.
REQ-031 reset asserted mid-pass SHALL abandon the pass with no further writes; after release the block SHALL wait in IDLE for a new start and restart from k=0.

Verification
REQ-032 Fill L1K0[i]=i, L1K1[i]=20'h80000|i; pulse start -> L2[2i]=i, L2[2i+1]=20'h80000|i for all i<1024, done pulse exactly 4097 cycles after start edge.
REQ-033 Protocol check every cycle -> never crd&cwr; csel=011/100 whenever crd=1; csel=101 whenever cwr=1; caddr_rd=k>>1 during READ.
REQ-034 Boundary: L1K1[1023]=20'hFFFFF, L1K0[0]=20'h00001 -> first write caddr_wr=0 data 20'h00001; last write caddr_wr=2047 data 20'hFFFFF; no write to 2048.
REQ-035 Pulse start at k=100 and again in DONE -> no restart, no extra writes, write count 2048.
REQ-036 Assert reset at k=500 during WRITE -> outputs zero immediately, no writes after reset; new start rewrites L2 from address 0 with correct data.
